pipe_stage_skid: RTL and testbench
==================================

# pipe_stage_skid

Parametrised elastic pipeline stage register: a generalisation of the fixed-type inter-stage latch into a WIDTH-bit stage with valid/ready handshaking, synchronous flush and an optional two-entry skid buffer. It sits between any two datapath stages (IF/ID, ID/EX, EX/MEM, MEM/WB). Back-pressure from the downstream stage propagates upstream without dropping or duplicating a packet. Flush converts the stage to a bubble.

## Interface
- WIDTH, 32: payload width in bits (≥1).
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  synchronous, active-high reset.
- flush  in  1  synchronous clear of all stage contents.
- in_valid  in  1  upstream presents a packet.
- in_data  in  WIDTH  upstream payload.
- in_ready  out  1  stage will accept a packet this cycle.
- out_valid  out  1  stage presents a packet downstream.
- out_data  out  WIDTH  payload to downstream.
- out_ready  in  1  downstream accepts this cycle.
- count  out  2  entries held (0..2).

## Operation
- Transfer rules:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
  - A packet transfers only on a fire. The stage does not depend on valid staying asserted without a fire.
- Storage:
  - main register drives out_data.
  - skid register exists only with the skid feature.
- State machine with skid (EMPTY, ONE, TWO), count = 0/1/2:
  - EMPTY: in_fire → ONE, main←in_data.
  - ONE, in_fire & out_fire → ONE, main←in_data.
  - ONE, in_fire & ~out_fire → TWO, skid←in_data.
  - ONE, ~in_fire & out_fire → EMPTY.
  - ONE, neither → hold.
  - TWO: out_fire → ONE, main←skid. Otherwise hold. in_fire is impossible in TWO.
- Outputs:
  - out_valid = (state ≠ EMPTY).
  - in_ready = (state ≠ TWO). It is a pure register decode with no combinational path from out_ready.
- Ordering: strict FIFO. A packet in skid always leaves after the packet in main.
- Stability: while out_valid & ~out_ready, out_data and out_valid hold unchanged.
- Flush:
  - When asserted, the next state is EMPTY, main and skid clear to 0, and count becomes 0.
  - Any in_fire or out_fire in the flush cycle still completes as a handshake. The upstream packet is discarded; the downstream packet is considered delivered.
  - flush beats every other transition. RST beats flush.
- Reset: identical to flush.
- No arithmetic beyond count. count never exceeds 2 (1 without skid).

## Timing
- Reset values: out_valid=0, out_data=0, count=0, in_ready=1. With skid, in_ready=1 from EMPTY; without skid, in_ready = ~out_valid | out_ready, which evaluates to 1.
- Latency: an in_fire at edge N gives out_valid=1 with that data after edge N. This is one cycle, in both configurations.
- Throughput: one packet per cycle sustained while out_ready=1.
- Skid back-pressure: out_ready deasserting costs at most one extra accepted packet, which lands in skid. in_ready falls one cycle after out_ready falls.
- Reset or flush mid-transfer: takes effect at the same edge. No partially held packet survives.
- Simultaneous in_fire, out_fire and flush: the result is EMPTY, with both handshakes complete.

## Configuration
- PIPE_STAGE_SKID_EN defined:
  - Two-entry behaviour as above.
  - in_ready is registered, which breaks the ready timing path between stages.
- PIPE_STAGE_SKID_EN undefined:
  - Single entry: no skid register; TWO state is absent.
  - in_ready = ~out_valid | out_ready, combinational.
  - ONE with in_fire & out_fire → ONE with main←in_data.
  - count ∈ {0,1}.
  - Flush, reset, ordering and stability rules are unchanged.

## Test plan
- Reset then stream: with WIDTH=32, hold RST for 2 cycles, then send 0x1..0x8 back-to-back with out_ready=1. Expect out_data 0x1..0x8 on 8 consecutive cycles starting one cycle after the first accept, and count=1 throughout.
- Back-pressure (skid): send 0xA, 0xB, 0xC with out_ready=0 from the second cycle.
  - Expect 0xA to hold on out_data, 0xB to go to skid, count=2 and in_ready=0.
  - Releasing out_ready then yields 0xA, then 0xB, then 0xC, with no loss or duplication.
- Back-pressure (no skid): under the same stimulus, expect in_ready=0 in the same cycle as out_ready=0, and 0xA, 0xB, 0xC delivered in order.
- Flush with full stage: at count=2, assert flush with in_valid=1, in_data=0xDEAD. Next cycle expect out_valid=0, out_data=0 and count=0; 0xDEAD is never emitted.
- Reset mid-stream: assert RST while 0x55 is held and out_ready=0. Next cycle expect all outputs at reset values; deassert RST, send 0x66, and expect 0x66 to be the next packet out.
- Random valid/ready: drive 10,000 cycles of random in_valid, out_ready and flush (10%). A scoreboard checks FIFO order, hold-stability and count within its bound.

Source files
------------

// File: rtl/pipe_stage_skid.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_stage_skid
//  Description : Elastic WIDTH-bit pipeline stage with valid/ready handshake,
//                synchronous flush and an optional two-entry skid buffer.
//                Build option: define PIPE_STAGE_SKID_EN for the two-entry
//                variant with a registered in_ready; leave it undefined for
//                the single-entry variant with a combinational in_ready.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_skid #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [1:0]       count
);

    // The encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic             in_fire;
    logic             out_fire;

`ifdef PIPE_STAGE_SKID_EN
    logic [WIDTH-1:0] skid_q, skid_d;

    // Ready is a pure state decode, so downstream ready never reaches upstream.
    assign in_ready = (state_q != ST_TWO);
`else
    // Single entry: accept when empty or when the held packet leaves this cycle.
    assign in_ready = ~out_valid | out_ready;
`endif

    assign out_valid = (state_q != ST_EMPTY);
    assign out_data  = main_q;
    assign count     = state_q;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    // Next-state and next-payload selection; flush overrides every transition.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
`ifdef PIPE_STAGE_SKID_EN
        skid_d  = skid_q;
`endif
        if (flush) begin
            state_d = ST_EMPTY;
            main_d  = '0;
`ifdef PIPE_STAGE_SKID_EN
            skid_d  = '0;
`endif
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state_d = ST_ONE;
                        main_d  = in_data;
                    end
                end
                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        main_d = in_data;
`ifdef PIPE_STAGE_SKID_EN
                    end else if (in_fire) begin
                        // Downstream stalled: the extra packet parks behind main.
                        state_d = ST_TWO;
                        skid_d  = in_data;
`endif
                    end else if (out_fire) begin
                        state_d = ST_EMPTY;
                    end
                end
`ifdef PIPE_STAGE_SKID_EN
                ST_TWO: begin
                    // in_ready is low here, so only the drain can happen.
                    if (out_fire) begin
                        state_d = ST_ONE;
                        main_d  = skid_q;
                    end
                end
`endif
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    // State and main payload register; reset matches a flush.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
        end
    end

`ifdef PIPE_STAGE_SKID_EN
    // Skid payload register, only present in the two-entry build.
    always_ff @(posedge CLK) begin
        if (RST) begin
            skid_q <= '0;
        end else begin
            skid_q <= skid_d;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_skid.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_stage_skid
//  Description : Self-checking bench for pipe_stage_skid. A queue model
//                predicts the outputs every cycle; directed sequences pin
//                the model with literal expectations. Follows the
//                PIPE_STAGE_SKID_EN build option of the design.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_skid;

`ifdef PIPE_STAGE_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready = 1'b0;
    logic [1:0]  count;

    int n_cmp = 0;
    int n_bad = 0;

    pipe_stage_skid #(.WIDTH(32)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .count     (count)
    );

    always #5 CLK = ~CLK;

    // ---------------- reference model: a bounded FIFO ----------------
    logic [31:0] q[$];
    logic [31:0] held = '0;      // value the output register must show
    bit          seen_rst = 0;

    function automatic logic m_in_ready();
`ifdef PIPE_STAGE_SKID_EN
        return (q.size() < CAP);
`else
        return (q.size() == 0) || out_ready;
`endif
    endfunction

    always @(posedge CLK) begin
        logic inf, outf;
        inf  = in_valid && m_in_ready();
        outf = (q.size() > 0) && out_ready;
        if (RST) seen_rst = 1;
        if (RST || flush) begin
            q.delete();
            held = '0;
        end else begin
            if (outf) void'(q.pop_front());
            if (inf) q.push_back(in_data);
            if (q.size() > 0) held = q[0];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 40)
                $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge CLK) begin
        if (seen_rst) begin
            chk("m_out_valid", {31'd0, out_valid}, {31'd0, q.size() > 0});
            chk("m_in_ready",  {31'd0, in_ready},  {31'd0, m_in_ready()});
            chk("m_count",     {30'd0, count},     q.size());
            chk("m_out_data",  out_data,           held);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_in(input logic iv, input logic [31:0] d, input logic ordy, input logic fl);
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        // Reset for two cycles.
        set_in(0, '0, 0, 0);
        RST = 1'b1;
        step();
        step();
        RST = 1'b0;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data",  out_data,           32'd0);
        chk("rst_count",     {30'd0, count},     32'd0);
        chk("rst_in_ready",  {31'd0, in_ready},  32'd1);

        // Back-to-back stream 0x1..0x8 with downstream always ready.
        for (int k = 1; k <= 8; k++) begin
            set_in(1, k, 1, 0);
            step();
            chk("stream_data",  out_data,           k);
            chk("stream_count", {30'd0, count},     32'd1);
            chk("stream_valid", {31'd0, out_valid}, 32'd1);
        end
        set_in(0, '0, 1, 0);
        step();
        chk("stream_drain", {30'd0, count}, 32'd0);

        // Back-pressure with 0xA, 0xB, 0xC.
        set_in(1, 32'hA, 1, 0);
        step();
        chk("bp_a", out_data, 32'hA);
`ifdef PIPE_STAGE_SKID_EN
        set_in(1, 32'hB, 0, 0);
        step();
        chk("bp_hold_a",  out_data,          32'hA);
        chk("bp_count2",  {30'd0, count},    32'd2);
        chk("bp_ready0",  {31'd0, in_ready}, 32'd0);
        set_in(1, 32'hC, 0, 0);
        step();
        chk("bp_stall_a", out_data,          32'hA);
        set_in(1, 32'hC, 1, 0);
        step();
        chk("bp_b",       out_data,          32'hB);
        chk("bp_count1",  {30'd0, count},    32'd1);
        set_in(1, 32'hC, 1, 0);
        step();
        chk("bp_c",       out_data,          32'hC);
`else
        set_in(1, 32'hB, 0, 0);
        #1;
        chk("bp_ready0",  {31'd0, in_ready}, 32'd0);
        step();
        chk("bp_hold_a",  out_data,          32'hA);
        chk("bp_count1",  {30'd0, count},    32'd1);
        set_in(1, 32'hB, 1, 0);
        step();
        chk("bp_b",       out_data,          32'hB);
        set_in(1, 32'hC, 1, 0);
        step();
        chk("bp_c",       out_data,          32'hC);
`endif
        set_in(0, '0, 1, 0);
        step();
        chk("bp_empty", {30'd0, count}, 32'd0);

        // Flush with the stage full; 0xDEAD must never appear.
        set_in(1, 32'h11, 0, 0);
        step();
        set_in(1, 32'h22, 0, 0);
        step();
        chk("fl_full", {30'd0, count}, CAP);
        set_in(1, 32'hDEAD, 0, 1);
        step();
        chk("fl_valid", {31'd0, out_valid}, 32'd0);
        chk("fl_data",  out_data,           32'd0);
        chk("fl_count", {30'd0, count},     32'd0);
        set_in(0, '0, 1, 0);
        step();
        chk("fl_no_dead", {31'd0, out_valid}, 32'd0);

        // Flush together with in_fire and out_fire: ends empty.
        set_in(1, 32'h33, 1, 0);
        step();
        chk("fl2_pre", out_data, 32'h33);
        set_in(1, 32'h44, 1, 1);
        step();
        chk("fl2_count", {30'd0, count}, 32'd0);
        chk("fl2_data",  out_data,       32'd0);

        // Reset while 0x55 is stalled, then 0x66 is the next packet.
        set_in(1, 32'h55, 0, 0);
        step();
        chk("rm_hold", out_data, 32'h55);
        set_in(0, '0, 0, 0);
        RST = 1'b1;
        step();
        chk("rm_valid", {31'd0, out_valid}, 32'd0);
        chk("rm_data",  out_data,           32'd0);
        chk("rm_count", {30'd0, count},     32'd0);
        chk("rm_ready", {31'd0, in_ready},  32'd1);
        RST = 1'b0;
        set_in(1, 32'h66, 1, 0);
        step();
        chk("rm_next", out_data, 32'h66);
        chk("rm_next_valid", {31'd0, out_valid}, 32'd1);

        // Random valid/ready traffic with occasional flush.
        for (int i = 0; i < 10000; i++) begin
            set_in(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 9) == 0));
            step();
        end
        set_in(0, '0, 1, 0);
        step();
        step();

        @(negedge CLK);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
